// File: rtl/timer_bank_pkg.sv
// Shared types and default sizes for the timer_bank block.
// Optional prescaler build is selected with TIMER_BANK_PRESCALE_EN.
package timer_bank_pkg;

   typedef enum logic {
      TMR_ONESHOT  = 1'b0,
      TMR_PERIODIC = 1'b1
   } tmr_mode_e;

   localparam int unsigned WIDTH_DEF = 10;
   localparam int unsigned NCH_DEF   = 2;
`ifdef TIMER_BANK_PRESCALE_EN
   localparam int unsigned PRESCALE_WIDTH_DEF = 8;
`endif

   function automatic tmr_mode_e mode_from_bit(input logic periodic);
      tmr_mode_e m;
      if (periodic) begin
         m = TMR_PERIODIC;
      end else begin
         m = TMR_ONESHOT;
      end
      return m;
   endfunction

endpackage

// File: rtl/timer_bank_chan.sv
// One down-counting timer channel: one-shot or auto-reload, with stop and
// a registered single-cycle done pulse.
module timer_bank_chan
   import timer_bank_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             start,
   input  logic             periodic,
   input  logic             stop,
   input  logic [WIDTH-1:0] start_time,
   output logic [WIDTH-1:0] timer,
   output logic             busy,
   output logic             done
);

   logic [WIDTH-1:0] counter_q, counter_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   tmr_mode_e        mode_q, mode_d;
   logic             run_q, run_d;
   logic             done_q, done_d;

   // Next state: start beats stop beats count/expire; done always self-clears.
   always_comb begin
      counter_d = counter_q;
      reload_d  = reload_q;
      mode_d    = mode_q;
      run_d     = run_q;
      done_d    = 1'b0;
      if (start) begin
         counter_d = start_time;
         reload_d  = start_time;
         mode_d    = mode_from_bit(periodic);
         run_d     = 1'b1;
      end else if (stop) begin
         if (run_q) begin
            run_d     = 1'b0;
            counter_d = '0;
         end else begin
            run_d     = run_q;
         end
      end else if (run_q && tick) begin
         if (counter_q != '0) begin
            counter_d = counter_q - WIDTH'(1'b1);
         end else begin
            done_d = 1'b1;
            if (mode_q == TMR_PERIODIC) begin
               counter_d = reload_q;
            end else begin
               run_d = 1'b0;
            end
         end
      end else begin
         counter_d = counter_q;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         counter_q <= '0;
         reload_q  <= '0;
         mode_q    <= TMR_ONESHOT;
         run_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         counter_q <= counter_d;
         reload_q  <= reload_d;
         mode_q    <= mode_d;
         run_q     <= run_d;
         done_q    <= done_d;
      end
   end

   assign timer = counter_q;
   assign busy  = run_q;
   assign done  = done_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of NCH independent timers with a shared tick and done_any summary.
// Define TIMER_BANK_PRESCALE_EN to add the shared tick prescaler.
module timer_bank
   import timer_bank_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned NCH   = NCH_DEF
`ifdef TIMER_BANK_PRESCALE_EN
   ,
   parameter int unsigned PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NCH-1:0]        start_enable,
   input  logic [NCH-1:0]        periodic,
   input  logic [NCH-1:0]        stop,
   input  logic [NCH*WIDTH-1:0]  start_time,
`ifdef TIMER_BANK_PRESCALE_EN
   input  logic [PRESCALE_WIDTH-1:0] prescale_div,
`endif
   output logic [NCH*WIDTH-1:0]  timer,
   output logic [NCH-1:0]        busy,
   output logic [NCH-1:0]        done,
   output logic                  done_any
);

   logic tick_s;

`ifdef TIMER_BANK_PRESCALE_EN
   logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;

   // Free-running divider; a divider lowered below the current count wraps at once.
   always_comb begin
      presc_d = presc_q;
      tick_s  = 1'b0;
      if (presc_q >= prescale_div) begin
         tick_s  = 1'b1;
         presc_d = '0;
      end else begin
         tick_s  = 1'b0;
         presc_d = presc_q + PRESCALE_WIDTH'(1'b1);
      end
   end

   // Prescaler count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end
`else
   assign tick_s = 1'b1;
`endif

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      timer_bank_chan #(
         .WIDTH(WIDTH)
      ) u_chan (
         .clk        (clk),
         .reset      (reset),
         .tick       (tick_s),
         .start      (start_enable[g]),
         .periodic   (periodic[g]),
         .stop       (stop[g]),
         .start_time (start_time[g*WIDTH +: WIDTH]),
         .timer      (timer[g*WIDTH +: WIDTH]),
         .busy       (busy[g]),
         .done       (done[g])
      );
   end

   assign done_any = |done;

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: tick-count model plus directed checks.
module tb_timer_bank;

   localparam int W  = 10;
   localparam int NC = 2;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [NC-1:0]   start_enable = '0;
   logic [NC-1:0]   periodic = '0;
   logic [NC-1:0]   stop = '0;
   logic [NC*W-1:0] start_time = '0;
`ifdef TIMER_BANK_PRESCALE_EN
   logic [7:0]      prescale_div = 8'd0;
`endif
   logic [NC*W-1:0] timer;
   logic [NC-1:0]   busy;
   logic [NC-1:0]   done;
   logic            done_any;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   timer_bank dut (
      .clk          (clk),
      .reset        (reset),
      .start_enable (start_enable),
      .periodic     (periodic),
      .stop         (stop),
      .start_time   (start_time),
`ifdef TIMER_BANK_PRESCALE_EN
      .prescale_div (prescale_div),
`endif
      .timer        (timer),
      .busy         (busy),
      .done         (done),
      .done_any     (done_any)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Model: per channel, the tick count since the last start decides everything.
   bit m_act[NC];
   int m_n[NC];
   bit m_per[NC];
   int m_k[NC];
   bit m_done[NC];
   int m_e;

   initial begin
      bit tk;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            for (int i = 0; i < NC; i++) begin
               m_act[i] = 1'b0; m_n[i] = 0; m_per[i] = 1'b0; m_k[i] = 0; m_done[i] = 1'b0;
            end
            m_e = 0;
         end else begin
`ifdef TIMER_BANK_PRESCALE_EN
            tk = (m_e % (int'(prescale_div) + 1)) == int'(prescale_div);
`else
            tk = 1'b1;
`endif
            m_e++;
            for (int i = 0; i < NC; i++) begin
               m_done[i] = 1'b0;
               if (start_enable[i]) begin
                  m_act[i] = 1'b1;
                  m_n[i]   = int'(start_time[i*W +: W]);
                  m_per[i] = periodic[i];
                  m_k[i]   = 0;
               end else if (stop[i]) begin
                  m_act[i] = 1'b0;
               end else if (m_act[i] && tk) begin
                  m_k[i]++;
                  if (m_per[i]) begin
                     if (m_k[i] % (m_n[i] + 1) == 0) m_done[i] = 1'b1;
                  end else if (m_k[i] == m_n[i] + 1) begin
                     m_done[i] = 1'b1;
                     m_act[i]  = 1'b0;
                  end
               end
            end
         end
      end
   end

   function automatic int exp_timer(input int i);
      if (!m_act[i]) return 0;
      if (m_per[i]) return m_n[i] - (m_k[i] % (m_n[i] + 1));
      return m_n[i] - m_k[i];
   endfunction

   // Compare every cycle on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i < NC; i++) begin
               chk($sformatf("cmp ch%0d timer", i), int'(timer[i*W +: W]), exp_timer(i));
               chk($sformatf("cmp ch%0d busy", i), int'(busy[i]), int'(m_act[i]));
               chk($sformatf("cmp ch%0d done", i), int'(done[i]), int'(m_done[i]));
               any = any | m_done[i];
            end
            chk("cmp done_any", int'(done_any), int'(any));
         end
      end
   end

   function automatic int tv(input int ch);
      return int'(timer[ch*W +: W]);
   endfunction

   task automatic arm(input int ch, input int n, input bit per);
      start_enable[ch]       = 1'b1;
      periodic[ch]           = per;
      start_time[ch*W +: W]  = W'(n);
   endtask

   task automatic step();
      @(negedge clk);
      start_enable = '0;
      stop         = '0;
   endtask

   task automatic chk_zero(input string name);
      chk({name, " timer0"}, tv(0), 0);
      chk({name, " timer1"}, tv(1), 0);
      chk({name, " busy"}, int'(busy), 0);
      chk({name, " done_any"}, int'(done_any), 0);
   endtask

   initial begin
      int cnt;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      reset  = 1'b0;
      chk_en = 1'b1;
      chk_zero("reset");

      // One-shot N=5 on ch0
      arm(0, 5, 1'b0);
      step();
      chk("os load", tv(0), 5);
      chk("os busy", int'(busy[0]), 1);
      for (int j = 1; j <= 5; j++) begin
         step();
         chk("os count", tv(0), 5 - j);
         chk("os early done", int'(done[0]), 0);
      end
      step();
      chk("os done", int'(done[0]), 1);
      chk("os busy drop", int'(busy[0]), 0);
      step();
      chk("os done width", int'(done[0]), 0);

      // Periodic N=3 on ch1 for 20 cycles, then stop
      arm(1, 3, 1'b1);
      step();
      cnt = 0;
      for (int j = 1; j <= 20; j++) begin
         step();
         if (done[1]) cnt++;
         if (j == 4) chk("per reload", tv(1), 3);
      end
      chk("per done count", cnt, 5);
      stop[1] = 1'b1;
      step();
      chk("per stop busy", int'(busy[1]), 0);
      chk("per stop timer", tv(1), 0);
      cnt = 0;
      repeat (8) begin
         step();
         if (done[1]) cnt++;
      end
      chk("per no done after stop", cnt, 0);

      // Restart ch0 at count 2 with N=4
      arm(0, 10, 1'b0);
      step();
      repeat (8) step();
      chk("rst count2", tv(0), 2);
      arm(0, 4, 1'b0);
      step();
      chk("rst reload", tv(0), 4);
      for (int j = 1; j <= 5; j++) begin
         step();
         chk("rst done timing", int'(done[0]), (j == 5) ? 1 : 0);
      end
      step();

      // Start and stop together: start wins; stop at expiry suppresses done
      arm(0, 3, 1'b0);
      stop[0] = 1'b1;
      step();
      chk("ss busy", int'(busy[0]), 1);
      chk("ss timer", tv(0), 3);
      repeat (3) step();
      chk("ss at zero", tv(0), 0);
      stop[0] = 1'b1;
      step();
      chk("stop at expiry done", int'(done[0]), 0);
      chk("stop at expiry busy", int'(busy[0]), 0);

      // N=0 on ch1, then stop while idle with done high
      arm(1, 0, 1'b0);
      step();
      chk("n0 busy", int'(busy[1]), 1);
      chk("n0 early done", int'(done[1]), 0);
      step();
      chk("n0 done", int'(done[1]), 1);
      chk("n0 busy drop", int'(busy[1]), 0);
      stop[1] = 1'b1;
      step();
      chk("idle stop done drop", int'(done[1]), 0);

      // Restart coinciding with expiry: no done
      arm(0, 2, 1'b0);
      step();
      repeat (2) step();
      arm(0, 6, 1'b0);
      step();
      chk("start at expiry done", int'(done[0]), 0);
      chk("start at expiry timer", tv(0), 6);
      stop[0] = 1'b1;
      step();

      // Asynchronous reset mid-count on both channels
      arm(0, 8, 1'b0);
      arm(1, 8, 1'b1);
      step();
      repeat (3) step();
      #2 reset = 1'b1;
      #1 chk_zero("async rst");
      @(negedge clk);
      chk_zero("rst held");
`ifdef TIMER_BANK_PRESCALE_EN
      prescale_div = 8'd3;
`endif
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk_zero("rst released");

`ifdef TIMER_BANK_PRESCALE_EN
      // Prescale div=3, one-shot N=2: ticks land on the 3rd, 7th, 11th edge after start
      arm(0, 2, 1'b0);
      step();
      for (int j = 1; j <= 11; j++) begin
         step();
         chk("psc done timing", int'(done[0]), (j == 11) ? 1 : 0);
         if (j == 2) chk("psc hold", tv(0), 2);
         if (j == 3) chk("psc first tick", tv(0), 1);
      end
`else
      arm(0, 1, 1'b0);
      step();
      chk("post rst load", tv(0), 1);
      step();
      chk("post rst count", tv(0), 0);
      step();
      chk("post rst done", int'(done[0]), 1);
`endif
      step();
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
